// File: rtl/wavetable_reader_if.sv
// rtl/wavetable_reader_if.sv - RAM read port and sample stream between wavetable_reader and its neighbours
interface wavetable_reader_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 20
);
    logic [ADDR_W-1:0] ram_sel;
    logic              ram_load;
    logic [DATA_W-1:0] ram_data;
    logic [DATA_W-1:0] sample_out;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output ram_sel, ram_load, sample_out, sample_valid,
        input  ram_data, sample_ready
    );

    modport slave (
        input  ram_sel, ram_load, sample_out, sample_valid,
        output ram_data, sample_ready
    );
endinterface

// File: rtl/wavetable_reader.sv
// rtl/wavetable_reader.sv - phase-accumulator wavetable reader with one-shot/loop playback
module wavetable_reader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 20,
    parameter int FRAC_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop_en,
    input  logic [ADDR_W-1:0]        start_addr,
    input  logic [ADDR_W-1:0]        end_addr,
    input  logic [ADDR_W+FRAC_W-1:0] phase_inc,
    input  logic                     sample_tick,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun,
    wavetable_reader_if.master       bus
);
    localparam int PW = ADDR_W + FRAC_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ISSUE, S_FETCH, S_OUTPUT} state_t;

    state_t                  state;
    logic [PW-1:0]           phase;
    logic [ADDR_W-1:0]       start_r;
    logic [ADDR_W-1:0]       eff_end_r;
    logic [ADDR_W+FRAC_W-1:0] inc_r;
    logic                    loop_r;
    logic                    last;

    logic [ADDR_W:0]         span;
    logic [PW-1:0]           span_fx;
    logic [PW-1:0]           phase_next;
    logic [PW-1:0]           phase_wrap;
    logic                    past_end;
    logic                    wrap_past_end;

    assign bus.ram_load = 1'b0;

    always_comb begin
        span          = {1'b0, eff_end_r} - {1'b0, start_r} + (ADDR_W+1)'(1);
        span_fx       = {span, FRAC_W'(0)};
        phase_next    = phase + PW'(inc_r);
        phase_wrap    = phase_next - span_fx;
        past_end      = phase_next[PW-1:FRAC_W] > {1'b0, eff_end_r};
        wrap_past_end = phase_wrap[PW-1:FRAC_W] > {1'b0, eff_end_r};
    end

    // ISSUE gives the RAM a cycle to register the new address; FETCH captures its output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            phase            <= '0;
            start_r          <= '0;
            eff_end_r        <= '0;
            inc_r            <= '0;
            loop_r           <= 1'b0;
            last             <= 1'b0;
            bus.ram_sel      <= '0;
            bus.sample_out   <= '0;
            bus.sample_valid <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state            <= S_IDLE;
                bus.sample_valid <= 1'b0;
                busy             <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (start) begin
                        start_r   <= start_addr;
                        eff_end_r <= (end_addr >= start_addr) ? end_addr : start_addr;
                        inc_r     <= phase_inc;
                        loop_r    <= loop_en;
                        phase     <= {1'b0, start_addr, FRAC_W'(0)};
                        last      <= 1'b0;
                        overrun   <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_WAIT;
                    end
                    S_WAIT: if (sample_tick) begin
                        bus.ram_sel <= phase[PW-2:FRAC_W];
                        state       <= S_ISSUE;
                    end
                    S_ISSUE: begin
                        if (sample_tick) overrun <= 1'b1;
                        state <= S_FETCH;
                    end
                    S_FETCH: begin
                        if (sample_tick) overrun <= 1'b1;
                        bus.sample_out   <= bus.ram_data;
                        bus.sample_valid <= 1'b1;
                        state            <= S_OUTPUT;
                        if (!past_end)
                            phase <= phase_next;
                        else if (!loop_r)
                            last <= 1'b1;
                        else if (wrap_past_end)
                            phase <= {1'b0, start_r, phase_next[FRAC_W-1:0]};
                        else
                            phase <= phase_wrap;
                    end
                    S_OUTPUT: begin
                        if (sample_tick) overrun <= 1'b1;
                        if (bus.sample_valid && bus.sample_ready) begin
                            bus.sample_valid <= 1'b0;
                            if (last) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state <= S_WAIT;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_wavetable_reader.sv
// tb/tb_wavetable_reader.sv - self-checking bench for wavetable_reader
module tb_wavetable_reader;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 20;
    localparam int FRAC_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst_n, start, stop, loop_en;
    logic [ADDR_W-1:0]        start_addr, end_addr;
    logic [ADDR_W+FRAC_W-1:0] phase_inc;
    logic                     tick_auto = 1'b0;
    logic                     tick_man = 1'b0;
    logic                     sample_tick;
    logic                     busy, done, overrun;

    assign sample_tick = tick_auto | tick_man;

    wavetable_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    wavetable_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAC_W(FRAC_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
        .start_addr(start_addr), .end_addr(end_addr), .phase_inc(phase_inc),
        .sample_tick(sample_tick), .busy(busy), .done(done), .overrun(overrun),
        .bus(bus)
    );

    logic [DATA_W-1:0] mem [4096];
    initial for (int a = 0; a < 4096; a++) mem[a] = DATA_W'(3 * a);
    always @(posedge clk) bus.ram_data <= mem[bus.ram_sel];

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fails++;
        $display("FAIL %s", name);
    endtask

    typedef struct { int addr; bit last; } exp_t;
    exp_t exp_q[$];
    int   got_q[$];
    int   got_addr[$];
    int   done_cnt = 0;
    bit   pending_done = 1'b0;
    bit   hold_prev = 1'b0;
    logic [DATA_W-1:0] held;
    exp_t cx;

    // Expected address stream from the playback rules, using phase in 1/256 units.
    task automatic build(input int s, input int e, input int inc, input bit lp, input int n);
        int eff, span, p, pn;
        exp_t x;
        eff = (e >= s) ? e : s;
        span = eff - s + 1;
        p = s * 256;
        for (int i = 0; i < n; i++) begin
            pn = p + inc;
            x.addr = p / 256;
            x.last = 1'b0;
            if (pn / 256 > eff) begin
                if (!lp) begin
                    x.last = 1'b1;
                    exp_q.push_back(x);
                    return;
                end
                if ((pn - span * 256) / 256 > eff) pn = s * 256 + pn % 256;
                else pn = pn - span * 256;
            end
            exp_q.push_back(x);
            p = pn;
        end
    endtask

    always @(negedge clk) begin
        check("ram_load", bus.ram_load, 0);
        check("done", done, pending_done);
        if (done === 1'b1) done_cnt++;
        pending_done = 1'b0;
        if (hold_prev && bus.sample_valid) check("sample_hold", bus.sample_out, held);
        hold_prev = rst_n && !stop && bus.sample_valid && !bus.sample_ready;
        held = bus.sample_out;
        if (rst_n && !stop && bus.sample_valid && bus.sample_ready) begin
            if (exp_q.size() == 0) begin
                fail_now("unexpected_sample");
            end else begin
                cx = exp_q.pop_front();
                check("sample_addr", bus.ram_sel, cx.addr);
                check("sample_data", bus.sample_out, 3 * cx.addr);
                got_q.push_back(int'(bus.sample_out));
                got_addr.push_back(int'(bus.ram_sel));
                pending_done = cx.last;
            end
        end
    end

    int tick_cnt = 0;
    int ticks_left = 0;
    always @(posedge clk) begin
        #1;
        tick_auto = (ticks_left > 0) && (tick_cnt % 8 == 0);
        if (tick_auto) ticks_left--;
        tick_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int s, input int e, input int inc, input bit lp);
        start_addr = ADDR_W'(s);
        end_addr   = ADDR_W'(e);
        phase_inc  = (ADDR_W+FRAC_W)'(inc);
        loop_en    = lp;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 300) begin step(); n++; end
        if (busy) fail_now({name, "_timeout_idle"});
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!bus.sample_valid && n < 100) begin step(); n++; end
        if (!bus.sample_valid) fail_now({name, "_timeout_valid"});
    endtask

    task automatic wait_ticks(input string name, input int left);
        int n = 0;
        while (ticks_left > left && n < 300) begin step(); n++; end
        if (ticks_left > left) fail_now({name, "_timeout_ticks"});
    endtask

    initial begin
        int lit_addr[7];
        int n;
        lit_addr = '{0, 1, 3, 0, 2, 3, 1};
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        start_addr = '0; end_addr = '0; phase_inc = '0;
        bus.sample_ready = 1'b1;
        step(); step();
        check("rst_busy", busy, 0);
        check("rst_valid", bus.sample_valid, 0);
        check("rst_ram_sel", bus.ram_sel, 0);
        check("rst_sample_out", bus.sample_out, 0);
        check("rst_overrun", overrun, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        step();

        build(0, 3, 'h180, 1'b1, 7);
        for (int i = 0; i < 7; i++) check("model_loop_addr", exp_q[i].addr, lit_addr[i]);
        exp_q.delete();
        build(20, 5, 'h100, 1'b0, 8);
        check("model_rev_size", exp_q.size(), 1);
        check("model_rev_addr", exp_q[0].addr, 20);
        check("model_rev_last", exp_q[0].last, 1);
        exp_q.delete();

        // one-shot 10..13
        got_q.delete(); done_cnt = 0;
        build(10, 13, 'h100, 1'b0, 16);
        pulse_start(10, 13, 'h100, 1'b0);
        ticks_left = 4;
        wait_idle("oneshot");
        step(); step();
        check("oneshot_count", got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) check("oneshot_data", got_q[i], 30 + 3 * i);
        check("oneshot_done_cnt", done_cnt, 1);
        check("oneshot_busy", busy, 0);
        check("oneshot_queue_empty", exp_q.size(), 0);

        // latency with a manual tick
        got_q.delete(); done_cnt = 0;
        build(50, 50, 'h100, 1'b0, 4);
        pulse_start(50, 50, 'h100, 1'b0);
        tick_man = 1'b1;
        step();
        tick_man = 1'b0;
        check("lat_ram_sel", bus.ram_sel, 50);
        check("lat_valid_n0", bus.sample_valid, 0);
        step();
        check("lat_valid_n1", bus.sample_valid, 0);
        step();
        check("lat_valid_n2", bus.sample_valid, 1);
        check("lat_data_n2", bus.sample_out, 150);
        wait_idle("latency");
        step(); step();
        check("lat_done_cnt", done_cnt, 1);

        // looped playback with fractional step
        got_q.delete(); got_addr.delete();
        build(0, 3, 'h180, 1'b1, 7);
        pulse_start(0, 3, 'h180, 1'b1);
        ticks_left = 7;
        n = 0;
        while (got_q.size() < 7 && n < 300) begin step(); n++; end
        if (got_q.size() < 7) fail_now("loop_timeout");
        wait_ticks("loop", 0);
        repeat (10) step();
        check("loop_count", got_q.size(), 7);
        for (int i = 0; i < 7 && i < got_q.size(); i++) begin
            check("loop_addr", got_addr[i], lit_addr[i]);
            check("loop_data", got_q[i], 3 * lit_addr[i]);
        end
        check("loop_overrun", overrun, 0);
        stop = 1'b1; step(); stop = 1'b0;
        check("loop_stop_busy", busy, 0);
        exp_q.delete();

        // backpressure across two ticks
        got_q.delete();
        build(5, 12, 'h100, 1'b1, 8);
        bus.sample_ready = 1'b0;
        pulse_start(5, 12, 'h100, 1'b1);
        ticks_left = 4;
        wait_valid("bp");
        wait_ticks("bp", 1);
        repeat (3) step();
        check("bp_overrun", overrun, 1);
        check("bp_valid", bus.sample_valid, 1);
        check("bp_data", bus.sample_out, 15);
        bus.sample_ready = 1'b1;
        wait_ticks("bp_resume", 0);
        repeat (8) step();
        check("bp_count", got_q.size(), 2);
        if (got_q.size() >= 2) begin
            check("bp_first", got_q[0], 15);
            check("bp_second", got_q[1], 18);
        end
        stop = 1'b1; step(); stop = 1'b0;
        check("bp_stop_busy", busy, 0);
        check("bp_stop_overrun_kept", overrun, 1);
        exp_q.delete();

        // end below start: single sample then done
        got_q.delete(); done_cnt = 0;
        build(20, 5, 'h100, 1'b0, 8);
        pulse_start(20, 5, 'h100, 1'b0);
        ticks_left = 3;
        wait_idle("rev");
        wait_ticks("rev", 0);
        repeat (3) step();
        check("rev_count", got_q.size(), 1);
        if (got_q.size() >= 1) check("rev_data", got_q[0], 60);
        check("rev_done_cnt", done_cnt, 1);

        // stop while a sample waits in OUTPUT
        got_q.delete(); done_cnt = 0;
        build(30, 40, 'h100, 1'b0, 16);
        bus.sample_ready = 1'b0;
        pulse_start(30, 40, 'h100, 1'b0);
        ticks_left = 1;
        wait_valid("stop");
        step();
        stop = 1'b1; step(); stop = 1'b0;
        check("stop_busy", busy, 0);
        check("stop_valid", bus.sample_valid, 0);
        exp_q.delete();
        step(); step();
        check("stop_done_cnt", done_cnt, 0);
        bus.sample_ready = 1'b1;

        // reset during FETCH, with overrun raised in ISSUE
        done_cnt = 0;
        build(100, 100, 'h100, 1'b0, 4);
        pulse_start(100, 100, 'h100, 1'b0);
        tick_man = 1'b1;
        step();
        step();
        tick_man = 1'b0;
        check("rstf_overrun_before", overrun, 1);
        rst_n = 1'b0;
        step();
        check("rstf_busy", busy, 0);
        check("rstf_valid", bus.sample_valid, 0);
        check("rstf_ram_sel", bus.ram_sel, 0);
        check("rstf_overrun", overrun, 0);
        check("rstf_sample_out", bus.sample_out, 0);
        rst_n = 1'b1;
        exp_q.delete();
        step(); step();
        check("rstf_done_cnt", done_cnt, 0);

        // start and stop together
        start_addr = 12'd7; end_addr = 12'd9; phase_inc = 20'h100; loop_en = 1'b0;
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check("startstop_busy", busy, 0);
        step();
        check("startstop_busy_later", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
